// File: rtl/param_stream_encoder_if.sv
// Handshake bundle for param_stream_encoder: input beat channel, output word channel and error pulse.
// slave is the encoder side; master is the source/sink side.
interface param_stream_encoder_if #(
  parameter int WIDTH_P = 32,
  parameter int WIDTH_Q = 60
);
  logic               o_ready;
  logic               i_valid;
  logic [6:0]         i_layer;
  logic [WIDTH_Q-1:0] i_param;
  logic               i_last;
  logic               i_ready;
  logic               o_valid;
  logic [WIDTH_P-1:0] o_tdata;
  logic               o_err;

  modport slave (
    output o_ready, o_valid, o_tdata, o_err,
    input  i_valid, i_layer, i_param, i_last, i_ready
  );

  modport master (
    input  o_ready, o_valid, o_tdata, o_err,
    output i_valid, i_layer, i_param, i_last, i_ready
  );
endinterface

// File: rtl/param_stream_encoder.sv
// Buffers a burst of parameter beats and emits it as a 0xA5-headed frame of 32-bit words.
// Optional trailing XOR checksum word: define PARAM_STREAM_CHECKSUM_EN.
module param_stream_encoder #(
  parameter int WIDTH_P   = 32,
  parameter int WIDTH_Q   = 60,
  parameter int DEPTH     = 16,
  parameter int NUM_LAYER = 85
) (
  input logic                  i_sclk,
  input logic                  i_rstp,
  param_stream_encoder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef PARAM_STREAM_CHECKSUM_EN
  localparam logic CHK_FLAG = 1'b1;
`else
  localparam logic CHK_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HDR,
    LO,
    HI
`ifdef PARAM_STREAM_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t             state_q;
  logic [6:0]         layer_q;
  logic [CW-1:0]      count_q;
  logic [AW-1:0]      rd_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH_P-1:0] tdata_q;
  logic               err_q;
`ifdef PARAM_STREAM_CHECKSUM_EN
  logic [WIDTH_P-1:0] chk_q;
`endif

  logic [WIDTH_Q-1:0] mem [DEPTH];

  logic          accept;
  logic          tx;
  logic          close;
  logic [CW-1:0] n_count;
  logic [6:0]    n_layer;
  logic [AW-1:0] wr_addr;
  logic [63:0]   cur_ext;
  logic [63:0]   nxt_ext;

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_tdata = tdata_q;
  assign bus.o_err   = err_q;

  assign accept = bus.i_valid && ready_q;
  assign tx     = valid_q && bus.i_ready;

  always_comb begin
    n_count = CW'(1);
    n_layer = bus.i_layer;
    wr_addr = '0;
    if (state_q != IDLE) begin
      n_count = count_q + CW'(1);
      n_layer = layer_q;
      wr_addr = count_q[AW-1:0];
    end
    close   = accept && (bus.i_last || (n_count == CW'(DEPTH)));
    // Zero-extend to 64 bits so the high word slice works for any beat width up to 64.
    cur_ext = 64'(mem[rd_q]);
    nxt_ext = 64'(mem[rd_q + AW'(1)]);
  end

  function automatic logic [31:0] header(input logic [6:0] l, input logic [CW-1:0] c);
    return {8'hA5, CHK_FLAG, l, 16'(c)};
  endfunction

  always_ff @(posedge i_sclk) begin
    if (accept) mem[wr_addr] <= bus.i_param;
  end

  always_ff @(posedge i_sclk or posedge i_rstp) begin
    if (i_rstp) begin
      state_q <= IDLE;
      layer_q <= '0;
      count_q <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      tdata_q <= '0;
      err_q   <= 1'b0;
`ifdef PARAM_STREAM_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, FILL: begin
          ready_q <= 1'b1;
          rd_q    <= '0;
`ifdef PARAM_STREAM_CHECKSUM_EN
          chk_q   <= '0;
`endif
          if (accept) begin
            count_q <= n_count;
            layer_q <= n_layer;
            state_q <= FILL;
            if (close) begin
              ready_q <= 1'b0;
              if (32'(n_layer) < NUM_LAYER) begin
                state_q <= HDR;
                valid_q <= 1'b1;
                tdata_q <= header(n_layer, n_count);
              end else begin
                // Out-of-range layer: drop the burst silently apart from the error pulse.
                state_q <= IDLE;
                err_q   <= 1'b1;
              end
            end
          end
        end
        HDR: begin
          if (tx) begin
            tdata_q <= cur_ext[31:0];
            state_q <= LO;
          end
        end
        LO: begin
          if (tx) begin
`ifdef PARAM_STREAM_CHECKSUM_EN
            chk_q   <= chk_q ^ tdata_q;
`endif
            tdata_q <= cur_ext[63:32];
            state_q <= HI;
          end
        end
        HI: begin
          if (tx) begin
`ifdef PARAM_STREAM_CHECKSUM_EN
            chk_q <= chk_q ^ tdata_q;
`endif
            if ({1'b0, rd_q} == count_q - CW'(1)) begin
`ifdef PARAM_STREAM_CHECKSUM_EN
              tdata_q <= chk_q ^ tdata_q;
              state_q <= CHK;
`else
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              tdata_q <= '0;
              state_q <= IDLE;
`endif
            end else begin
              rd_q    <= rd_q + AW'(1);
              tdata_q <= nxt_ext[31:0];
              state_q <= LO;
            end
          end
        end
`ifdef PARAM_STREAM_CHECKSUM_EN
        CHK: begin
          if (tx) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            tdata_q <= '0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stream_encoder.sv
// Directed self-checking bench for param_stream_encoder (DEPTH=16, WIDTH_Q=60, NUM_LAYER=85).
module tb_param_stream_encoder;

  logic sclk = 1'b0;
  logic rstp = 1'b1;
  always #5 sclk = ~sclk;

  param_stream_encoder_if #(.WIDTH_P(32), .WIDTH_Q(60)) bus ();

  param_stream_encoder #(
    .WIDTH_P  (32),
    .WIDTH_Q  (60),
    .DEPTH    (16),
    .NUM_LAYER(85)
  ) dut (
    .i_sclk(sclk),
    .i_rstp(rstp),
    .bus   (bus)
  );

`ifdef PARAM_STREAM_CHECKSUM_EN
  localparam logic [31:0] HB = 32'h0080_0000;
  logic [31:0] csum;
`else
  localparam logic [31:0] HB = 32'h0000_0000;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] pv(input int i);
    return {28'(i), 32'hC000_0000 + 32'(i)};
  endfunction

  task automatic start_frame(input logic [31:0] hdr);
    exp_q.delete();
    exp_q.push_back(hdr | HB);
`ifdef PARAM_STREAM_CHECKSUM_EN
    csum = '0;
`endif
  endtask

  task automatic add_beat(input logic [59:0] p);
    exp_q.push_back(p[31:0]);
    exp_q.push_back({4'h0, p[59:32]});
`ifdef PARAM_STREAM_CHECKSUM_EN
    csum = csum ^ p[31:0] ^ {4'h0, p[59:32]};
`endif
  endtask

  task automatic end_frame();
`ifdef PARAM_STREAM_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endtask

  // Present a beat and hold it until accepted; returns on the negedge after acceptance.
  task automatic send(input logic [6:0] l, input logic [59:0] p, input bit last);
    int w = 0;
    bus.i_valid = 1'b1;
    bus.i_layer = l;
    bus.i_param = p;
    bus.i_last  = last;
    while (!bus.o_ready && w < 300) begin
      @(negedge sclk);
      w++;
    end
    if (!bus.o_ready) chk("send_timeout", 32'(bus.o_ready), 32'd1);
    @(posedge sclk);
    @(negedge sclk);
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp, input int stall_pct, input bit strict);
    logic [31:0] held = '0;
    bit stalled = 1'b0;
    bit got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      if (bus.o_valid) begin
        if (stalled) chk({tag, "_hold"}, bus.o_tdata, held);
        bus.i_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
        if (bus.i_ready) begin
          chk(tag, bus.o_tdata, exp);
          got = 1'b1;
          @(posedge sclk);
        end else begin
          held    = bus.o_tdata;
          stalled = 1'b1;
        end
      end else if (strict || stalled) begin
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        got = 1'b1;
      end
      @(negedge sclk);
    end
    if (!got) chk({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic recv_frame(input string tag, input int stall_pct, input bit strict);
    foreach (exp_q[i]) recv($sformatf("%s_w%0d", tag, i), exp_q[i], stall_pct, strict);
    chk({tag, "_end_valid"}, 32'(bus.o_valid), 32'd0);
    bus.i_ready = 1'b1;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_layer = '0;
    bus.i_param = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge sclk);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_tdata", bus.o_tdata, 32'd0);
    chk("rst_err",   32'(bus.o_err),   32'd0);
    rstp = 1'b0;
    @(negedge sclk);
    chk("rst_ready_rise", 32'(bus.o_ready), 32'd1);

    // Single beat, layer 5: o_ready low for the whole frame, high right after
    start_frame(32'hA505_0001);
    add_beat(60'h0AB_CDEF_0123_4567);
    end_frame();
    send(7'd5, 60'h0AB_CDEF_0123_4567, 1'b1);
    foreach (exp_q[i]) begin
      chk($sformatf("t1_ready_low%0d", i), 32'(bus.o_ready), 32'd0);
      recv($sformatf("t1_w%0d", i), exp_q[i], 0, 1'b1);
    end
    chk("t1_ready_back", 32'(bus.o_ready), 32'd1);
    chk("t1_valid_end",  32'(bus.o_valid), 32'd0);

    // Burst of 3 to layer 84; layer change on a middle beat is ignored
    start_frame(32'hA554_0003);
    add_beat(60'd1); add_beat(60'd2); add_beat(60'd3);
    end_frame();
    send(7'd84, 60'd1, 1'b0);
    send(7'd7,  60'd2, 1'b0);
    send(7'd84, 60'd3, 1'b1);
    recv_frame("t2", 0, 1'b1);

    // 20 beats to layer 1: forced close at 16, beats 17-20 wait
    start_frame(32'hA501_0010);
    for (int i = 1; i <= 16; i++) begin
      add_beat(pv(i));
      send(7'd1, pv(i), 1'b0);
    end
    end_frame();
    chk("t3_forced_ready", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_layer = 7'd1;
    bus.i_param = pv(17);
    recv_frame("t3a", 0, 1'b1);
    start_frame(32'hA501_0004);
    for (int i = 17; i <= 20; i++) begin
      add_beat(pv(i));
      send(7'd1, pv(i), i == 20);
    end
    end_frame();
    recv_frame("t3b", 0, 1'b1);

    // Invalid layer 100: no output, one-cycle error pulse
    send(7'd100, 60'h11, 1'b0);
    send(7'd100, 60'h22, 1'b1);
    chk("t4_err_pulse", 32'(bus.o_err),   32'd1);
    chk("t4_valid",     32'(bus.o_valid), 32'd0);
    chk("t4_ready_low", 32'(bus.o_ready), 32'd0);
    @(negedge sclk);
    chk("t4_err_clear", 32'(bus.o_err),   32'd0);
    chk("t4_ready",     32'(bus.o_ready), 32'd1);
    chk("t4_valid2",    32'(bus.o_valid), 32'd0);

    // 4-beat burst with 50% random output stalls
    start_frame(32'hA507_0004);
    add_beat(60'hFFF_1111_2222_3333);
    add_beat(60'h123_4567_89AB_CDEF);
    add_beat(60'h800_0000_0000_0001);
    add_beat(60'h0F0_F0F0_5A5A_A5A5);
    end_frame();
    send(7'd7, 60'hFFF_1111_2222_3333, 1'b0);
    send(7'd7, 60'h123_4567_89AB_CDEF, 1'b0);
    send(7'd7, 60'h800_0000_0000_0001, 1'b0);
    send(7'd7, 60'h0F0_F0F0_5A5A_A5A5, 1'b1);
    recv_frame("t5", 50, 1'b0);

    // Reset asserted during LO of a 3-beat frame
    send(7'd2, 60'd9,  1'b0);
    send(7'd2, 60'd10, 1'b0);
    send(7'd2, 60'd11, 1'b1);
    chk("t6_hdr", bus.o_tdata, 32'hA502_0003 | HB);
    @(negedge sclk);
    chk("t6_lo", bus.o_tdata, 32'd9);
    rstp = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("t6_rst_ready", 32'(bus.o_ready), 32'd0);
    @(negedge sclk);
    rstp = 1'b0;
    start_frame(32'hA500_0001);
    add_beat(60'd5);
    end_frame();
    send(7'd0, 60'd5, 1'b1);
    recv_frame("t6b", 0, 1'b1);

    // 2-beat frame (params 1, 2); trailing checksum 0x00000003 in the checksum build
    start_frame(32'hA503_0002);
    add_beat(60'd1); add_beat(60'd2);
    end_frame();
    send(7'd3, 60'd1, 1'b0);
    send(7'd3, 60'd2, 1'b1);
    recv_frame("t7", 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
